// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input registered selector with valid/ready handshake, stall and flush.
// MODE 0 selects via sel; MODE 1 round-robins among valid inputs starting at ptr.
module mux_n_pipe #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN),
   parameter int MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
);
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] src_q, src_d, ptr_q, ptr_d, cand;
   logic             valid_q, valid_d, has_cand, load_en, accept;
   always_comb begin
      cand = '0;
      has_cand = 1'b0;
      if (MODE == 0) begin
         cand = sel;
         has_cand = 32'(sel) < NUM_IN;
      end else begin
         // descending scan so the last hit is the nearest channel at or after ptr
         for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (in_valid[(int'(ptr_q) + j) % NUM_IN]) begin
               cand = SEL_W'((int'(ptr_q) + j) % NUM_IN);
               has_cand = 1'b1;
            end
         end
      end
   end
   assign load_en  = !flush && (!valid_q || out_ready);
   assign in_ready = (load_en && has_cand) ? {{(NUM_IN-1){1'b0}}, 1'b1} << cand : '0;
   assign accept   = |(in_valid & in_ready);
   always_comb begin
      valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
      data_d  = accept ? in_data[cand*WIDTH +: WIDTH] : data_q;
      src_d   = accept ? cand : src_q;
      ptr_d   = (MODE != 0 && accept) ? ((cand == SEL_W'(NUM_IN - 1)) ? '0 : cand + 1'b1) : ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end
   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed scenarios plus randomized run against a behavioural model.
// Instances: 0 = MODE0/N4, 1 = MODE1/N4, 2 = MODE0/N3, 3 = MODE1/N3.
module tb_mux_n_pipe;
   logic       clk, rst_n, flush, out_ready;
   logic [4:0] id [4][4];
   logic [3:0] iv [4];
   logic [1:0] isel [4];
   logic [3:0] rdy [4];
   logic [3:0] ra, rb;
   logic [2:0] rc, rd;
   logic [4:0] od [4];
   logic [1:0] os [4];
   logic       ov [4];
   int checks = 0, errors = 0;
   logic       mv [4];
   logic [4:0] md [4];
   int         ms [4], mp [4];

   mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .MODE(0)) u_a (.clk(clk), .rst_n(rst_n),
      .in_data({id[0][3], id[0][2], id[0][1], id[0][0]}), .in_valid(iv[0]), .in_ready(ra),
      .sel(isel[0]), .flush(flush), .out_data(od[0]), .out_src(os[0]), .out_valid(ov[0]), .out_ready(out_ready));
   mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .MODE(1)) u_b (.clk(clk), .rst_n(rst_n),
      .in_data({id[1][3], id[1][2], id[1][1], id[1][0]}), .in_valid(iv[1]), .in_ready(rb),
      .sel(isel[1]), .flush(flush), .out_data(od[1]), .out_src(os[1]), .out_valid(ov[1]), .out_ready(out_ready));
   mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .MODE(0)) u_c (.clk(clk), .rst_n(rst_n),
      .in_data({id[2][2], id[2][1], id[2][0]}), .in_valid(iv[2][2:0]), .in_ready(rc),
      .sel(isel[2]), .flush(flush), .out_data(od[2]), .out_src(os[2]), .out_valid(ov[2]), .out_ready(out_ready));
   mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .MODE(1)) u_d (.clk(clk), .rst_n(rst_n),
      .in_data({id[3][2], id[3][1], id[3][0]}), .in_valid(iv[3][2:0]), .in_ready(rd),
      .sel(isel[3]), .flush(flush), .out_data(od[3]), .out_src(os[3]), .out_valid(ov[3]), .out_ready(out_ready));

   assign rdy[0] = ra;
   assign rdy[1] = rb;
   assign rdy[2] = {1'b0, rc};
   assign rdy[3] = {1'b0, rd};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int n_of(int k);
      return k < 2 ? 4 : 3;
   endfunction

   // the channel the rules pick this cycle, or -1 when there is none
   function automatic int m_cand(int k);
      int n = n_of(k);
      if (k % 2 == 0) return int'(isel[k]) < n ? int'(isel[k]) : -1;
      for (int j = 0; j < n; j++)
         if (iv[k][(mp[k] + j) % n]) return (mp[k] + j) % n;
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(int k);
      int c = m_cand(k);
      if (flush || (mv[k] && !out_ready) || c < 0) return 4'h0;
      return 4'(1 << c);
   endfunction

   function automatic void m_step(int k);
      int  c = m_cand(k);
      bit  acc = (m_ready(k) != 0) && iv[k][c];
      if (flush) mv[k] = 1'b0;
      else if (acc) begin
         mv[k] = 1'b1;
         md[k] = id[k][c];
         ms[k] = c;
         if (k % 2 == 1) mp[k] = (c + 1) % n_of(k);
      end else if (out_ready) mv[k] = 1'b0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv[k] = '0;
         isel[k] = '0;
         for (int i = 0; i < 4; i++) id[k][i] = '0;
      end
   endtask

   task automatic do_reset;
      clear_inputs();
      out_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      clear_inputs();
      out_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({ov[k], od[k], os[k]} !== 8'h0) begin
            errors++;
            $display("FAIL reset_async k=%0d got v=%b d=%h s=%0d want 0", k, ov[k], od[k], os[k]);
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_select;
      isel[0] = 2'd2; iv[0] = 4'b0100; id[0][2] = 5'h1A; out_ready = 1'b1;
      #1;
      checks++;
      if (rdy[0] !== 4'b0100) begin errors++; $display("FAIL sel_ready got %b want 0100", rdy[0]); end
      tick();
      checks++;
      if ({ov[0], od[0], os[0]} !== {1'b1, 5'h1A, 2'd2}) begin
         errors++; $display("FAIL sel_out got v=%b d=%h s=%0d want 1 1a 2", ov[0], od[0], os[0]);
      end
   endtask

   task automatic test_stall;
      out_ready = 1'b0; id[0][2] = 5'h05;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (rdy[0] !== 4'b0000) begin errors++; $display("FAIL stall_ready got %b want 0000", rdy[0]); end
         tick();
         checks++;
         if ({ov[0], od[0], os[0]} !== {1'b1, 5'h1A, 2'd2}) begin
            errors++; $display("FAIL stall_hold got v=%b d=%h s=%0d want 1 1a 2", ov[0], od[0], os[0]);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (rdy[0] !== 4'b0100) begin errors++; $display("FAIL unstall_ready got %b want 0100", rdy[0]); end
      tick();
      checks++;
      if ({ov[0], od[0]} !== {1'b1, 5'h05}) begin
         errors++; $display("FAIL unstall_out got v=%b d=%h want 1 05", ov[0], od[0]);
      end
      iv[0] = 4'b0000; isel[0] = 2'd1;
      #1;
      checks++;
      if (rdy[0] !== 4'b0010) begin errors++; $display("FAIL ready_no_valid got %b want 0010", rdy[0]); end
      tick();
      checks++;
      if ({ov[0], od[0], os[0]} !== {1'b0, 5'h05, 2'd2}) begin
         errors++; $display("FAIL drain got v=%b d=%h s=%0d want 0 05 2", ov[0], od[0], os[0]);
      end
   endtask

   task automatic test_async_reset;
      isel[0] = 2'd2; iv[0] = 4'b0100; id[0][2] = 5'h0F; iv[1] = 4'b0010; out_ready = 1'b1;
      tick();
      checks++;
      if ({ov[0], od[0]} !== {1'b1, 5'h0F}) begin errors++; $display("FAIL pre_reset got v=%b d=%h want 1 0f", ov[0], od[0]); end
      #2 rst_n = 1'b0; iv[1] = 4'hF;
      #1;
      checks++;
      if ({ov[0], od[0], os[0]} !== 8'h0) begin
         errors++; $display("FAIL midreset got v=%b d=%h s=%0d want 0", ov[0], od[0], os[0]);
      end
      checks++;
      if (rdy[1] !== 4'b0001) begin errors++; $display("FAIL reset_ptr got %b want 0001", rdy[1]); end
      #1 rst_n = 1'b1; iv[1] = 4'h0;
      tick();
      checks++;
      if ({ov[0], od[0], os[0]} !== {1'b1, 5'h0F, 2'd2}) begin
         errors++; $display("FAIL first_after_reset got v=%b d=%h s=%0d want 1 0f 2", ov[0], od[0], os[0]);
      end
   endtask

   task automatic test_rr_fair;
      do_reset();
      iv[1] = 4'hF; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) id[1][i] = 5'(i + 8);
      #1;
      checks++;
      if (rdy[1] !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b want 0001", rdy[1]); end
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if ({ov[1], od[1], os[1]} !== {1'b1, 5'(c % 4 + 8), 2'(c % 4)}) begin
            errors++; $display("FAIL rr_fair c=%0d got v=%b d=%0d s=%0d want 1 %0d %0d", c, ov[1], od[1], os[1], c % 4 + 8, c % 4);
         end
      end
   endtask

   task automatic test_rr_skip;
      logic [3:0] pat [4] = '{4'b0100, 4'b0010, 4'b1001, 4'b1001};
      logic [3:0] exp_r [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
      int         exp_s [4] = '{2, 1, 3, 0};
      for (int c = 0; c < 4; c++) begin
         iv[1] = pat[c];
         #1;
         checks++;
         if (rdy[1] !== exp_r[c]) begin errors++; $display("FAIL rr_skip_ready c=%0d got %b want %b", c, rdy[1], exp_r[c]); end
         tick();
         checks++;
         if (int'(os[1]) != exp_s[c] || ov[1] !== 1'b1) begin
            errors++; $display("FAIL rr_skip_src c=%0d got v=%b s=%0d want 1 %0d", c, ov[1], os[1], exp_s[c]);
         end
      end
      iv[1] = 4'h0;
   endtask

   task automatic test_flush;
      do_reset();
      iv[1] = 4'hF; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) id[1][i] = 5'(i + 8);
      tick();
      flush = 1'b1;
      #1;
      checks++;
      if (rdy[1] !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", rdy[1]); end
      tick();
      checks++;
      if ({ov[1], od[1], os[1]} !== {1'b0, 5'd8, 2'd0}) begin
         errors++; $display("FAIL flush_out got v=%b d=%0d s=%0d want 0 8 0", ov[1], od[1], os[1]);
      end
      flush = 1'b0;
      #1;
      checks++;
      if (rdy[1] !== 4'b0010) begin errors++; $display("FAIL flush_ptr got %b want 0010", rdy[1]); end
      tick();
      checks++;
      if ({ov[1], od[1], os[1]} !== {1'b1, 5'd9, 2'd1}) begin
         errors++; $display("FAIL after_flush got v=%b d=%0d s=%0d want 1 9 1", ov[1], od[1], os[1]);
      end
      iv[1] = 4'h0;
   endtask

   task automatic test_out_of_range;
      do_reset();
      isel[2] = 2'd3; iv[2] = 4'b0111; id[2][2] = 5'h11; out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (rdy[2] !== 4'b0000) begin errors++; $display("FAIL oor_ready got %b want 0000", rdy[2]); end
         tick();
         checks++;
         if (ov[2] !== 1'b0) begin errors++; $display("FAIL oor_valid got %b want 0", ov[2]); end
      end
      isel[2] = 2'd2;
      tick();
      checks++;
      if ({ov[2], od[2], os[2]} !== {1'b1, 5'h11, 2'd2}) begin
         errors++; $display("FAIL oor_recover got v=%b d=%h s=%0d want 1 11 2", ov[2], od[2], os[2]);
      end
   endtask

   task automatic test_random;
      logic [3:0] er;
      do_reset();
      for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = '0; ms[k] = 0; mp[k] = 0; end
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 4; k++) begin
            iv[k] = 4'($urandom);
            isel[k] = 2'($urandom);
            for (int i = 0; i < 4; i++) id[k][i] = 5'($urandom);
         end
         out_ready = $urandom_range(0, 9) < 7;
         flush = $urandom_range(0, 9) == 0;
         #1;
         for (int k = 0; k < 4; k++) begin
            er = m_ready(k);
            checks++;
            if (rdy[k] !== er) begin errors++; $display("FAIL rand_ready k=%0d c=%0d got %b want %b", k, c, rdy[k], er); end
         end
         @(posedge clk);
         for (int k = 0; k < 4; k++) m_step(k);
         #1;
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[k] !== mv[k] || od[k] !== md[k] || int'(os[k]) != ms[k]) begin
               errors++; $display("FAIL rand_out k=%0d c=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d", k, c, ov[k], od[k], os[k], mv[k], md[k], ms[k]);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_select();
      test_stall();
      test_async_reset();
      test_rr_fair();
      test_rr_skip();
      test_flush();
      test_out_of_range();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
